// File: rtl/imm_decode_ctrl_pkg.sv
// Shared definitions for the decode-stage immediate path: format select codes,
// RV32I major opcodes, the occupancy state type and the held-entry layout.
package imm_decode_ctrl_pkg;

   localparam logic [2:0] FMT_I    = 3'b000;
   localparam logic [2:0] FMT_S    = 3'b001;
   localparam logic [2:0] FMT_B    = 3'b010;
   localparam logic [2:0] FMT_U    = 3'b011;
   localparam logic [2:0] FMT_J    = 3'b100;
   localparam logic [2:0] FMT_NONE = 3'b111;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } occ_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [2:0]  fmt;
      logic        illegal;
   } entry_t;

   localparam entry_t ENTRY_RST = '{instr: 32'h0, imm: 32'h0, fmt: FMT_NONE, illegal: 1'b0};

   // Formats without an immediate must not carry whatever the generator drives.
   function automatic logic [31:0] entry_imm(input logic [2:0] fmt, input logic [31:0] imm);
      return (fmt == FMT_NONE) ? 32'h0 : imm;
   endfunction

endpackage

// File: rtl/imm_fmt_decode.sv
// Combinational RV32I opcode classifier: maps the major opcode onto the
// immediate generator's format select and flags unrecognised encodings.
module imm_fmt_decode
   import imm_decode_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output logic [2:0] fmt,
   output logic       illegal
);

   always_comb begin
      fmt     = FMT_NONE;
      illegal = 1'b0;
      if (opcode[1:0] != 2'b11) begin
         illegal = 1'b1;
      end else begin
         case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_FENCE, OPC_SYSTEM: fmt = FMT_I;
            OPC_STORE:            fmt = FMT_S;
            OPC_BRANCH:           fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:   fmt = FMT_U;
            OPC_JAL:              fmt = FMT_J;
            OPC_OP:               fmt = FMT_NONE;
            default:              illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/imm_decode_ctrl.sv
// Decode-stage controller: classifies incoming instructions for the external
// immediate generator and holds results in a main + skid entry pair toward execute.
module imm_decode_ctrl
   import imm_decode_ctrl_pkg::*;
#(
   parameter int PC_W = 32,
   parameter bit SKID = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic [31:0]     gen_instr,
   output logic [2:0]      gen_ctr,
   input  logic [31:0]     gen_imm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [PC_W-1:0] out_pc,
   output logic [31:0]     out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   occ_state_e      state_q, state_d;
   entry_t          main_q, skid_q, in_entry;
   logic [PC_W-1:0] main_pc_q, skid_pc_q;
   logic [2:0]      dec_fmt;
   logic            dec_illegal;
   logic            accept, pop, load_main, load_skid, shift_skid;

   imm_fmt_decode u_fmt_decode (
      .opcode  (in_instr[6:0]),
      .fmt     (dec_fmt),
      .illegal (dec_illegal)
   );

   assign gen_instr = in_instr;
   assign gen_ctr   = dec_fmt;

   always_comb begin
      in_entry = '{instr: in_instr, imm: entry_imm(dec_fmt, gen_imm), fmt: dec_fmt, illegal: dec_illegal};
   end

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   // Handshake outputs depend only on occupancy (plus out_ready without skid).
   always_comb begin
      out_valid = (state_q != ST_EMPTY);
      if (SKID) begin
         in_ready = (state_q != ST_TWO) & ~flush & rst_n;
      end else begin
         in_ready = ((state_q == ST_EMPTY) | out_ready) & ~flush & rst_n;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (accept) state_d = ST_ONE;
         ST_ONE: begin
            if (accept & ~pop)      state_d = SKID ? ST_TWO : ST_ONE;
            else if (pop & ~accept) state_d = ST_EMPTY;
         end
         ST_TWO:   if (pop) state_d = ST_ONE;
         default:  state_d = ST_EMPTY;
      endcase
      if (flush) state_d = ST_EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_EMPTY;
      else        state_q <= state_d;
   end

   assign load_main  = accept & ((state_q == ST_EMPTY) | pop);
   assign load_skid  = accept & (state_q == ST_ONE) & ~pop;
   assign shift_skid = pop & (state_q == ST_TWO);

   // Main entry: refilled from input when it drains or is empty, else from skid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q    <= ENTRY_RST;
         main_pc_q <= '0;
      end else if (load_main) begin
         main_q    <= in_entry;
         main_pc_q <= in_pc;
      end else if (shift_skid) begin
         main_q    <= skid_q;
         main_pc_q <= skid_pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_q    <= ENTRY_RST;
         skid_pc_q <= '0;
      end else if (load_skid) begin
         skid_q    <= in_entry;
         skid_pc_q <= in_pc;
      end
   end

   assign out_instr   = main_q.instr;
   assign out_pc      = main_pc_q;
   assign out_imm     = main_q.imm;
   assign out_fmt     = main_q.fmt;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Bench for imm_decode_ctrl: external generator model on gen_*, queue-based
// reference of the two-entry stage, directed scenarios then random traffic.
module tb_imm_decode_ctrl;

   localparam int PC_W = 32;

   logic            clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
   logic [31:0]     in_instr, gen_instr, gen_imm, out_instr, out_imm;
   logic [2:0]      gen_ctr, out_fmt;
   logic [PC_W-1:0] in_pc, out_pc;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } exp_t;

   exp_t       q[$];
   exp_t       m_e;
   logic [3:0] m_cl;
   bit         m_acc, m_pop;

   logic [6:0] opc_tab [11] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011,
                                7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                7'b0110011};

   imm_decode_ctrl #(.PC_W(PC_W), .SKID(1'b1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .gen_instr   (gen_instr),
      .gen_ctr     (gen_ctr),
      .gen_imm     (gen_imm),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_imm     (out_imm),
      .out_fmt     (out_fmt),
      .out_illegal (out_illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // External immediate generator; unsupported selects return junk on purpose.
   function automatic logic [31:0] gen_model(input logic [31:0] i, input logic [2:0] c);
      case (c)
         3'b000:  return {{20{i[31]}}, i[31:20]};
         3'b001:  return {{20{i[31]}}, i[31:25], i[11:7]};
         3'b010:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'b011:  return {i[31:12], 12'h000};
         3'b100:  return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: return i ^ 32'hDEADBEEF;
      endcase
   endfunction

   always_comb gen_imm = gen_model(gen_instr, gen_ctr);

   // Returns {illegal, fmt} for an instruction word.
   function automatic logic [3:0] classify(input logic [31:0] i);
      case (i[6:0])
         7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: return 4'b0_000;
         7'b0100011: return 4'b0_001;
         7'b1100011: return 4'b0_010;
         7'b0110111, 7'b0010111: return 4'b0_011;
         7'b1101111: return 4'b0_100;
         7'b0110011: return 4'b0_111;
         default:    return 4'b1_111;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: check outputs, then advance the queue for the coming edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         chk("rst_out_valid", 32'(out_valid), 32'h0);
         chk("rst_in_ready", 32'(in_ready), 32'h0);
         chk("rst_out_fmt", 32'(out_fmt), 32'h7);
         chk("rst_out_instr", out_instr, 32'h0);
         chk("rst_out_imm", out_imm, 32'h0);
         chk("rst_out_pc", 32'(out_pc), 32'h0);
         chk("rst_out_illegal", 32'(out_illegal), 32'h0);
      end else begin
         m_cl = classify(in_instr);
         chk("gen_ctr", 32'(gen_ctr), 32'(m_cl[2:0]));
         chk("gen_instr", gen_instr, in_instr);
         chk("in_ready", 32'(in_ready), 32'(q.size() < 2 && !flush));
         chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
         if (q.size() != 0 && out_valid) begin
            chk("out_instr", out_instr, q[0].instr);
            chk("out_pc", 32'(out_pc), q[0].pc);
            chk("out_imm", out_imm, q[0].imm);
            chk("out_fmt", 32'(out_fmt), 32'(q[0].fmt));
            chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
         end
         m_acc = in_valid && (q.size() < 2) && !flush;
         m_pop = (q.size() != 0) && out_ready;
         m_e.instr = in_instr;
         m_e.pc    = 32'(in_pc);
         m_e.fmt   = m_cl[2:0];
         m_e.ill   = m_cl[3];
         m_e.imm   = (m_cl[2:0] == 3'b111) ? 32'h0 : gen_model(in_instr, m_cl[2:0]);
         if (m_pop) void'(q.pop_front());
         if (m_acc) q.push_back(m_e);
         if (flush) q.delete();
      end
   end

   initial begin
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = '0; out_ready = 1'b0;
      #3 rst_n = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      chk("reset_out_fmt", 32'(out_fmt), 32'h7);
      chk("reset_in_ready", 32'(in_ready), 32'h0);
      tick(); tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("release_in_ready", 32'(in_ready), 32'h1);

      // ADDI with all-ones immediate
      tick();
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h1000;
      @(negedge clk);
      chk("addi_gen_ctr", 32'(gen_ctr), 32'h0);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("addi_out_valid", 32'(out_valid), 32'h1);
      chk("addi_out_imm", out_imm, 32'hFFFFFFFF);
      chk("addi_out_fmt", 32'(out_fmt), 32'h0);
      chk("addi_out_pc", 32'(out_pc), 32'h1000);

      // SW then LUI
      tick();
      in_valid = 1'b1; in_instr = 32'h00112623; in_pc = 32'h1004;
      @(negedge clk);
      chk("sw_gen_ctr", 32'(gen_ctr), 32'h1);
      tick();
      in_instr = 32'h123452B7; in_pc = 32'h1008;
      @(negedge clk);
      chk("sw_out_imm", out_imm, 32'h0000000C);
      chk("lui_gen_ctr", 32'(gen_ctr), 32'h3);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("lui_out_imm", out_imm, 32'h12345000);
      chk("lui_out_fmt", 32'(out_fmt), 32'h3);

      // ADD (no immediate) then an unknown opcode
      tick();
      in_valid = 1'b1; in_instr = 32'h002081B3;
      tick();
      in_instr = 32'h0000007F;
      @(negedge clk);
      chk("add_out_fmt", 32'(out_fmt), 32'h7);
      chk("add_out_imm", out_imm, 32'h0);
      chk("add_out_illegal", 32'(out_illegal), 32'h0);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("ill_out_illegal", 32'(out_illegal), 32'h1);
      chk("ill_out_fmt", 32'(out_fmt), 32'h7);
      chk("ill_out_imm", out_imm, 32'h0);

      // Backpressure: three back-to-back pushes, only two fit
      tick();
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093;
      tick();
      in_instr = 32'h00A00113;
      tick();
      in_instr = 32'h00F00193;
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'h0);
      chk("full_head", out_instr, 32'h00500093);
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      chk("drain_head0", out_instr, 32'h00500093);
      tick();
      @(negedge clk);
      chk("drain_head1", out_instr, 32'h00A00113);
      chk("drain_in_ready", 32'(in_ready), 32'h1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("drain_head2", out_instr, 32'h00F00193);
      tick();

      // Flush while full with a competing input
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093;
      tick();
      in_instr = 32'h00A00113;
      tick();
      in_instr = 32'h00C00213; flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 32'(in_ready), 32'h0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 32'(out_valid), 32'h0);
      chk("flush_in_ready_after", 32'(in_ready), 32'h1);
      tick();
      @(negedge clk);
      chk("flush_no_accept", 32'(out_valid), 32'h0);

      // Asynchronous reset while full
      tick();
      in_valid = 1'b1; in_instr = 32'h00500093;
      tick();
      in_instr = 32'h00A00113;
      tick();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("areset_out_valid", 32'(out_valid), 32'h0);
      chk("areset_out_fmt", 32'(out_fmt), 32'h7);
      chk("areset_in_ready", 32'(in_ready), 32'h0);
      tick(); tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("areset_release_ready", 32'(in_ready), 32'h1);
      chk("areset_release_valid", 32'(out_valid), 32'h0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         tick();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         in_pc     = $urandom;
         in_instr  = $urandom;
         if ($urandom_range(0, 7) != 0) in_instr[6:0] = opc_tab[$urandom_range(0, 10)];
      end
      tick();
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
